// File: rtl/prog_loader.sv
// Run-time writable program store: byte-stream loader into a 2**ADDR_W x WORD_W array, combinational CPU read, NOP while loading.
// One byte per accepted edge; rx_ready high only in LEN/DATA/CHECK, so the stream may stall or gap freely.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 35,
  parameter int BPW    = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] data,
  output logic              loading,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int ASM_W = 8 * BPW;
  localparam int IDX_W = $clog2(BPW + 1);
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  n_words;
  logic [7:0]        chk;
  logic [IDX_W-1:0]  byte_idx;
  logic [ASM_W-1:0]  asm_q;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] mem [2**ADDR_W];

  logic              accept;
  logic [ASM_W-1:0]  asm_next;
  logic              word_end;
  logic              top_bad;
  logic              last_word;
  logic              we;

  assign loading   = (state == S_LEN) || (state == S_DATA) || (state == S_CHECK);
  assign rx_ready  = loading;
  assign accept    = rx_valid && rx_ready;
  assign asm_next  = (asm_q << 8) | ASM_W'(rx_data);
  assign word_end  = (byte_idx == IDX_W'(BPW - 1));
  // Any bit above the instruction width marks a malformed word.
  assign top_bad   = ((asm_next >> WORD_W) != '0);
  assign last_word = ((word_count + CNT_W'(1)) == n_words);
  assign we        = accept && (state == S_DATA) && word_end && !top_bad;

  assign data = loading ? '0 : mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= asm_next[WORD_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      n_words    <= '0;
      chk        <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      waddr      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_LEN;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            n_words  <= (rx_data == 8'd0) ? CNT_W'(2**ADDR_W) : CNT_W'(rx_data);
            chk      <= rx_data;
            byte_idx <= '0;
            waddr    <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q <= asm_next;
            chk   <= chk ^ rx_data;
            if (word_end) begin
              if (top_bad) begin
                err   <= 1'b1;
                state <= S_ERROR;
              end else begin
                waddr      <= waddr + ADDR_W'(1);
                word_count <= word_count + CNT_W'(1);
                byte_idx   <= '0;
                if (last_word) state <= S_CHECK;
              end
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (rx_data == chk) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: streams programs, then reads the array back through addr/data.
module tb_prog_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  addr;
  logic [34:0] data;
  logic        loading;
  logic        done;
  logic        err;
  logic [8:0]  word_count;

  prog_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .addr(addr), .data(data), .loading(loading), .done(done),
    .err(err), .word_count(word_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          a;
    logic [34:0] w;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  bit          abort = 1'b0;
  exp_t        sbq[$];
  logic [34:0] wq[$];
  logic [34:0] model [256];

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (abort) return;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) begin
      total++; bad++; abort = 1'b1;
      $display("FAIL rx_ready_timeout: rx_ready=%0b required 1 for byte %02h", rx_ready, b);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic drain_scoreboard(input string name);
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      addr = 8'(e.a);
      #1;
      total++;
      if (data !== e.w) begin
        bad++;
        $display("FAIL %s_read[%0d]: got %09h required %09h", name, e.a, data, e.w);
      end
    end
  endtask

  // Streams wq as one program; every complete legal word lands in the model and scoreboard.
  task automatic run_load(input logic [7:0] lbyte, input bit gaps, input bit mid_start,
                          input bit bad_chk, input string name);
    int          n;
    logic [7:0]  chk;
    logic [39:0] wb;
    n   = (lbyte == 8'd0) ? 256 : int'(lbyte);
    chk = lbyte;
    pulse_start();
    total++;
    if (loading !== 1'b1 || done !== 1'b0 || err !== 1'b0 || word_count !== 9'd0) begin
      bad++;
      $display("FAIL %s_start: loading=%0b done=%0b err=%0b wc=%0d required 1 0 0 0",
               name, loading, done, err, word_count);
    end
    send_byte(lbyte, gaps);
    for (int k = 0; k < n; k++) begin
      wb = {5'b0, wq[k]};
      for (int i = 0; i < 5; i++) begin
        send_byte(wb[39-8*i -: 8], gaps);
        chk ^= wb[39-8*i -: 8];
        if (mid_start && i == 2) pulse_start();
      end
      model[k] = wq[k];
      sbq.push_back('{k, wq[k]});
      if (k < 4) begin
        addr = 8'($urandom_range(0, 255));
        #1;
        total++;
        if (data !== 35'd0) begin
          bad++;
          $display("FAIL %s_nop_hold: data=%09h required 0 at addr %0d", name, data, addr);
        end
      end
    end
    send_byte(bad_chk ? (chk ^ 8'h01) : chk, gaps);
    @(negedge clock);
    total++;
    if (done !== !bad_chk || err !== bad_chk || loading !== 1'b0 || word_count !== 9'(n)) begin
      bad++;
      $display("FAIL %s_status: done=%0b err=%0b loading=%0b wc=%0d required %0b %0b 0 %0d",
               name, done, err, loading, word_count, !bad_chk, bad_chk, n);
    end
    drain_scoreboard(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; addr = 8'h00;
    repeat (2) @(negedge clock);
    total++;
    if (rx_ready !== 1'b0 || loading !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_count !== 9'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b loading=%0b done=%0b err=%0b wc=%0d required all 0",
               rx_ready, loading, done, err, word_count);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_normal();
    wq = '{35'h0_1234_5678, 35'h5_5555_5555, 35'h6_AAAA_0001, 35'h1_2345_6789};
    run_load(8'h04, 1'b0, 1'b0, 1'b0, "preload");
    wq = '{35'h0_0000_0001, 35'h2_0000_00AA, 35'h7_FFFF_FFFF};
    run_load(8'h03, 1'b0, 1'b0, 1'b0, "normal");
    addr = 8'd3;
    #1;
    total++;
    if (data !== 35'h1_2345_6789) begin
      bad++;
      $display("FAIL normal_addr3_kept: got %09h required 123456789", data);
    end
  endtask

  task automatic test_bad_checksum();
    run_load(8'h03, 1'b0, 1'b0, 1'b1, "badchk");
  endtask

  task automatic test_illegal_top();
    logic [7:0] bw[5];
    bw = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(i == 4 ? 8'h55 : 8'h00, 1'b0);
    model[0] = 35'h55;
    sbq.push_back('{0, 35'h55});
    for (int i = 0; i < 5; i++) send_byte(bw[i], 1'b0);
    total++;
    if (err !== 1'b1 || done !== 1'b0 || loading !== 1'b0 || rx_ready !== 1'b0 || word_count !== 9'd1) begin
      bad++;
      $display("FAIL illegal_status: err=%0b done=%0b loading=%0b rdy=%0b wc=%0d required 1 0 0 0 1",
               err, done, loading, rx_ready, word_count);
    end
    sbq.push_back('{1, model[1]});
    drain_scoreboard("illegal");
  endtask

  task automatic test_backpressure();
    wq = '{35'h0_0000_0001, 35'h2_0000_00AA, 35'h7_FFFF_FFFF};
    run_load(8'h03, 1'b1, 1'b1, 1'b0, "gaps");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(i == 0 ? 8'h03 : 8'hC3, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    addr  = 8'd0;
    #1;
    total++;
    if (rx_ready !== 1'b0 || loading !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_count !== 9'd0) begin
      bad++;
      $display("FAIL midreset_state: rdy=%0b loading=%0b done=%0b err=%0b wc=%0d required all 0",
               rx_ready, loading, done, err, word_count);
    end
    total++;
    if (data !== 35'h3_C3C3_C3C3) begin
      bad++;
      $display("FAIL midreset_mem0: got %09h required 3c3c3c3c3", data);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wq = {};
    for (int k = 0; k < 256; k++) wq.push_back({3'($urandom_range(0, 7)), 32'($urandom)});
    run_load(8'h00, 1'b0, 1'b0, 1'b0, "full256");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_checksum();
    test_illegal_top();
    test_backpressure();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
